tile_config_receiver: RTL
=========================

# tile_config_receiver

Tile-side responder for the configuration bus that the bitstream loader drives into a PE tile. Samples `config_addr`/`config_data` each rising edge of `clk_in`, matches the tile ID field, and writes the data word into a local bank of configuration registers whose contents drive the PE and switch-box muxes. It also offers optional readback, a write counter and a sticky error flag for bitstream debug.

## Interface
- `REG_COUNT`, 16: number of 32-bit configuration registers (2..256).
- `FEATURE_ID`, 8'h00: feature field value that selects this register bank.
- `clk_in` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tile_id` input 16: static tile ID, compared with `config_addr[15:0]`.
- `config_addr` input 32: `[15:0]` tile ID (16'hFFFF = broadcast), `[23:16]` feature ID, `[31:24]` register index.
- `config_data` input 32: write data.
- `config_write` input 1: write strobe, one word per asserted cycle.
- `config_read` input 1: read strobe (readback build only).
- `read_data` output 32: readback word.
- `read_valid` output 1: one-cycle qualifier for `read_data`.
- `cfg_regs` output 32*REG_COUNT: flattened register bank, register i at `[32*i+31:32*i]`.
- `cfg_update` output REG_COUNT: one-cycle pulse per register written.
- `cfg_write_count` output 16: accepted writes, saturating at 16'hFFFF.
- `cfg_error` output 1: sticky error flag.

## Operation
- Stage 1 (S1): capture `config_addr`, `config_data`, `config_write`, `config_read` into registers every cycle.
- Stage 2 (S2): decode the S1 contents. Hit = feature == `FEATURE_ID` and (tile == `tile_id`, or tile == 16'hFFFF with write).
- Write hit with index < `REG_COUNT`: update the register, pulse its `cfg_update` bit, increment `cfg_write_count` (saturating).
- Write hit with index >= `REG_COUNT`: no register change, set `cfg_error`.
- Non-hit words are ignored silently. This includes the idle word addr=0/data=0, unless `tile_id` is 0.
- Read hit (unicast only), index in range: `read_data` = register value, `read_valid`=1.
  - Out of range: `read_data`=0, `read_valid`=1, set `cfg_error`.
  - Broadcast read: ignored.
- `config_write` and `config_read` both high in the same S1 word: perform the write only, drop the read, set `cfg_error`.
- `cfg_error` clears only on `reset`.
- Reset values: all `cfg_regs`=0, `cfg_update`=0, `cfg_write_count`=0, `cfg_error`=0, `read_data`=0, `read_valid`=0, S1 strobes=0.
- Reset asserted mid-stream: any in-flight S1 word is discarded. No partial writes are allowed.

## Timing
- Strobe sampled at rising edge N (S1). The register update, `cfg_update` pulse and counter increment become visible after edge N+1.
- `read_valid`/`read_data` are registered, valid in the cycle after edge N+1. They hold for exactly one cycle; otherwise `read_valid`=0 and `read_data` holds its last value.
- Back-to-back strobes every cycle are sustained, throughput one word per cycle.
- Read-after-write to the same register on consecutive cycles returns the new data, because S2 processes words in order.
- Inputs may change on the falling edge (loader drives on negedge). No combinational path from any input to any output.

## Configuration
- `CFG_READBACK_EN` defined: the read path exists as above.
- Not defined:
  - `config_read` is ignored entirely (no error on simultaneous write/read).
  - `read_data` is tied 0 and `read_valid` is tied 0.
  - The readback mux is not synthesized.

## Test plan
- Reset, then write addr 32'h0300_0015 / data 32'hDEAD_BEEF with `tile_id`=16'h15 -> after edge N+1, register 3 = DEADBEEF, `cfg_update`=16'h0008 for one cycle, count=1.
- Write addr 32'h0300_0016 (wrong tile) and addr 32'h0301_0015 (wrong feature) -> no register change, count unchanged, `cfg_error`=0.
- Broadcast write addr 32'h0500_FFFF data 1234 -> register 5 = 1234. Then read addr 32'h0500_0015 -> `read_valid` one cycle, `read_data`=1234 (with `CFG_READBACK_EN`).
- Write index 16 (addr 32'h1000_0015) with REG_COUNT=16 -> no update, `cfg_error`=1 sticky until `reset`.
- 16 back-to-back writes, index i, data i*3 -> all registers correct, count=16.
  - Then assert `reset` mid-burst -> all outputs 0 asynchronously.
- Simultaneous `config_write`/`config_read` to register 2 with data 7 -> register 2 = 7, no `read_valid`, `cfg_error`=1.
  - Without the macro: `cfg_error`=0 and `read_valid` stays 0.

Source files
------------

// File: rtl/tile_config_receiver.sv
// Tile-side configuration bus responder: S1 captures the bus word, S2 decodes it into a local register bank.
// The readback path (read_data/read_valid, read errors) is built only when CFG_READBACK_EN is defined.
module tile_config_receiver #(
  parameter int         REG_COUNT  = 16,
  parameter logic [7:0] FEATURE_ID = 8'h00
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [15:0]             tile_id,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  input  logic                    config_write,
  input  logic                    config_read,
  output logic [31:0]             read_data,
  output logic                    read_valid,
  output logic [32*REG_COUNT-1:0] cfg_regs,
  output logic [REG_COUNT-1:0]    cfg_update,
  output logic [15:0]             cfg_write_count,
  output logic                    cfg_error
);

  localparam logic [8:0]  REG_LIMIT = 9'(REG_COUNT);
  localparam logic [15:0] BCAST_ID  = 16'hFFFF;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [31:0]          s1_addr_q;
  logic [31:0]          s1_data_q;
  logic                 s1_wr_q;
  logic [31:0]          regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] cfg_update_q;
  logic [REG_COUNT-1:0] cfg_update_d;
  logic [15:0]          count_q;
  logic [15:0]          count_d;
  logic                 error_q;
  logic                 error_d;

  logic [15:0] s2_tile_s;
  logic [7:0]  s2_feat_s;
  logic [7:0]  s2_idx_s;
  logic        feat_ok_s;
  logic        tile_ok_s;
  logic        bcast_s;
  logic        in_range_s;
  logic        wr_hit_s;
  logic        wr_en_s;
  logic        wr_oor_s;
  logic        rd_err_s;

  assign s2_tile_s  = s1_addr_q[15:0];
  assign s2_feat_s  = s1_addr_q[23:16];
  assign s2_idx_s   = s1_addr_q[31:24];
  assign feat_ok_s  = (s2_feat_s == FEATURE_ID);
  assign tile_ok_s  = (s2_tile_s == tile_id);
  assign bcast_s    = (s2_tile_s == BCAST_ID);
  assign in_range_s = ({1'b0, s2_idx_s} < REG_LIMIT);
  assign wr_hit_s   = s1_wr_q & feat_ok_s & (tile_ok_s | bcast_s);
  assign wr_en_s    = wr_hit_s & in_range_s;
  assign wr_oor_s   = wr_hit_s & ~in_range_s;

  // S1: capture the bus word every cycle; reset drops any in-flight word
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_addr_q <= 32'h0;
      s1_data_q <= 32'h0;
      s1_wr_q   <= 1'b0;
    end else begin
      s1_addr_q <= config_addr;
      s1_data_q <= config_data;
      s1_wr_q   <= config_write;
    end
  end

  // S2 next-state: one-hot update pulse, saturating write counter, sticky error
  always_comb begin
    cfg_update_d = {REG_COUNT{1'b0}};
    for (int i = 0; i < REG_COUNT; i++) begin
      if (wr_en_s && (s2_idx_s == 8'(i))) begin
        cfg_update_d[i] = 1'b1;
      end else begin
        cfg_update_d[i] = 1'b0;
      end
    end
    if (wr_en_s && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
    if (wr_oor_s || rd_err_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  // S2 state: register bank, update pulse, counter and error flag
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= 32'h0;
      end
      cfg_update_q <= {REG_COUNT{1'b0}};
      count_q      <= 16'h0000;
      error_q      <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (cfg_update_d[i]) begin
          regs_q[i] <= s1_data_q;
        end
      end
      cfg_update_q <= cfg_update_d;
      count_q      <= count_d;
      error_q      <= error_d;
    end
  end

`ifdef CFG_READBACK_EN
  logic        s1_rd_q;
  logic        rd_hit_s;
  logic        rd_oor_s;
  logic        dual_s;
  logic [31:0] rd_word_s;
  logic [31:0] read_data_q;
  logic [31:0] read_data_d;
  logic        read_valid_q;
  logic        read_valid_d;

  // A word carrying both strobes is treated as a write; the read is dropped and flagged
  assign rd_hit_s = s1_rd_q & ~s1_wr_q & feat_ok_s & tile_ok_s & ~bcast_s;
  assign rd_oor_s = rd_hit_s & ~in_range_s;
  assign dual_s   = s1_rd_q & wr_hit_s;
  assign rd_err_s = rd_oor_s | dual_s;

  // Readback mux as an AND-OR tree so the index width never has to match the bank depth
  always_comb begin
    rd_word_s = 32'h0;
    for (int i = 0; i < REG_COUNT; i++) begin
      rd_word_s = rd_word_s | ((s2_idx_s == 8'(i)) ? regs_q[i] : 32'h0);
    end
  end

  // Read response next-state: data holds its last value when no read is answered
  always_comb begin
    read_valid_d = rd_hit_s;
    if (rd_hit_s) begin
      read_data_d = in_range_s ? rd_word_s : 32'h0;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Read strobe capture and registered read response
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_rd_q      <= 1'b0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
    end else begin
      s1_rd_q      <= config_read;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
`else
  logic unused_read_s;

  assign unused_read_s = config_read;
  assign rd_err_s      = 1'b0;
  assign read_data     = 32'h0;
  assign read_valid    = 1'b0;
`endif

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign cfg_regs[32*g +: 32] = regs_q[g];
  end

  assign cfg_update      = cfg_update_q;
  assign cfg_write_count = count_q;
  assign cfg_error       = error_q;

endmodule
